// File: rtl/mmu_ctx_loader.sv
// MMU context loader: walks the mapping table in memory and programs every
// MMU entry, saving the fault register first and restoring it at the end.
module mmu_ctx_loader #(
  parameter int RV   = 16,
  parameter int PA   = RV,
  parameter int NMMU = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [RV-1:0] base,
  output logic          busy,
  output logic          cpu_hold,
  output logic          done,
  output logic          mem_req,
  output logic [RV-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [RV-1:0] mem_rdata,
  input  logic          mmu_fault,
  output logic          mmu_reg_write,
  output logic [RV-1:0] mmu_reg_data,
  input  logic [RV-1:0] mmu_reg_read
);

  localparam int VB        = $clog2(NMMU);
  localparam int UNTOUCHED = RV - VB;
  localparam int IW        = $clog2(4 * NMMU);
  localparam int BPW       = RV / 8;
  localparam int PHYS_W    = PA - UNTOUCHED;
  localparam logic [IW-1:0] LAST = IW'(4 * NMMU - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_FETCH,
    S_SEL,
    S_ENT,
    S_RESTORE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [RV-1:0] base_q, base_d;
  logic [RV-1:0] saved_q, saved_d;
  logic [RV-1:0] word_q, word_d;

  logic [RV-1:0] addr_cur;
  logic [RV-1:0] sel_data;
  logic [RV-1:0] ent_data;
  logic [RV-1:0] rst_data;
  logic          unused_bits;

  assign unused_bits = ^{saved_q[0], word_q[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      saved_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      saved_q <= saved_d;
      word_q  <= word_d;
    end
  end

  // Table walk wraps modulo 2^RV through the adder width.
  assign addr_cur = base_q + (RV'(idx_q) * RV'(BPW));

  always_comb begin
    sel_data = '0;
    sel_data[RV-1:UNTOUCHED] = idx_q[VB-1:0];
    sel_data[4] = idx_q[IW-1];
    sel_data[3] = idx_q[IW-2];
    ent_data = '0;
    ent_data[UNTOUCHED +: PHYS_W] = word_q[UNTOUCHED +: PHYS_W];
    ent_data[UNTOUCHED-1:1] = word_q[UNTOUCHED-1:1];
    ent_data[0] = 1'b1;
    rst_data = {saved_q[RV-1:1], 1'b0};
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    base_d        = base_q;
    saved_d       = saved_q;
    word_d        = word_q;
    done          = 1'b0;
    mem_req       = 1'b0;
    mem_addr      = '0;
    mmu_reg_write = 1'b0;
    mmu_reg_data  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base;
          idx_d   = '0;
          state_d = S_SAVE;
        end
      end
      S_SAVE: begin
        saved_d = mmu_reg_read;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = addr_cur;
        if (mem_ack) begin
          word_d  = mem_rdata;
          state_d = S_SEL;
        end
      end
      // A pending fault capture drops the MMU write, so hold and retry.
      S_SEL: begin
        mmu_reg_write = 1'b1;
        mmu_reg_data  = sel_data;
        if (!mmu_fault) state_d = S_ENT;
      end
      S_ENT: begin
        mmu_reg_write = 1'b1;
        mmu_reg_data  = ent_data;
        if (!mmu_fault) begin
          if (idx_q == LAST) begin
            state_d = S_RESTORE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_RESTORE: begin
        mmu_reg_write = 1'b1;
        mmu_reg_data  = rst_data;
        if (!mmu_fault) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign cpu_hold = busy;

endmodule
